// File: rtl/spi_slave_stream_if.sv
// SPI pad bundle plus the byte handshake with the upstream JPEG-to-SPI sequencer.
interface spi_slave_stream_if;
   logic       spi_sck;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [7:0] spi_data;
   logic       spi_rd;

   modport slave (
      input  spi_sck, spi_cs_n, spi_mosi, spi_data,
      output spi_miso, spi_miso_oe, spi_rd
   );

   modport master (
      output spi_sck, spi_cs_n, spi_mosi, spi_data,
      input  spi_miso, spi_miso_oe, spi_rd
   );
endinterface

// File: rtl/spi_slave_stream.sv
// Mode-0 SPI slave that streams upstream bytes out on MISO after a read command.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | CS high, MISO pad released
// ST_CMD    | first byte: status shifts out, command shifts in
// ST_STREAM | read command seen: spi_data bytes shift out, spi_rd per byte
// ST_DUMMY  | any other command: zeros shift out until CS rises
module spi_slave_stream #(
   parameter logic [7:0] CMD_READ    = 8'h0B,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_rdy,
   spi_slave_stream_if.slave bus,
   output logic              busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_STREAM, ST_DUMMY} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q,  cs_prev_q;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall, cs_rise;

   state_t     state_q,   state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_q,      tx_d;
   logic [6:0] rx_q,      rx_d;
   logic       load_q,    load_d;
   logic       rd_q,      rd_d;
   logic       miso_q,    miso_d;

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  bus.spi_sck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise =  sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s &  sck_prev_q;
   assign cs_fall  = ~cs_s  &  cs_prev_q;
   assign cs_rise  =  cs_s  & ~cs_prev_q;

   // CS chain resets low so a CS still held low across reset never looks like
   // a fresh select; the host has to release and re-assert it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         tx_q        <= 8'h00;
         rx_q        <= 7'h00;
         load_q      <= 1'b0;
         rd_q        <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         load_q      <= load_d;
         rd_q        <= rd_d;
         miso_q      <= miso_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      load_d    = load_q;
      rd_d      = 1'b0;
      miso_d    = tx_q[7];

      if (state_q == ST_IDLE) begin
         if (cs_fall) begin
            state_d   = ST_CMD;
            tx_d      = {7'b0, frame_rdy};
            bit_cnt_d = 3'd0;
            rx_d      = 7'h00;
            load_d    = 1'b0;
         end
      end else if (cs_rise) begin
         state_d = ST_IDLE;
         load_d  = 1'b0;
      end else begin
         if (sck_rise) begin
            rx_d      = {rx_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               load_d = 1'b1;
               unique case (state_q)
                  ST_CMD:    state_d = ({rx_q, mosi_s} == CMD_READ) ? ST_STREAM : ST_DUMMY;
                  ST_STREAM: rd_d    = 1'b1;
                  default:   ;
               endcase
            end
         end
         // The fall after a byte boundary starts the next byte instead of shifting.
         if (sck_fall) begin
            if (load_q) begin
               tx_d   = (state_q == ST_STREAM) ? bus.spi_data : 8'h00;
               load_d = 1'b0;
            end else begin
               tx_d = {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   assign bus.spi_miso    = miso_q;
   assign bus.spi_miso_oe = (state_q != ST_IDLE);
   assign bus.spi_rd      = rd_q;
   assign busy            = (state_q == ST_STREAM);

endmodule

// File: tb/tb_spi_slave_stream.sv
// Scoreboard bench: host model drives SPI, upstream model is a byte counter.
module tb_spi_slave_stream;
   localparam int SYNC = 3;

   logic clk;
   logic reset_n;
   logic frame_rdy;
   logic busy;
   logic [7:0] up_cnt;
   logic       up_reload;
   logic       rd_p1;

   spi_slave_stream_if bus ();

   spi_slave_stream #(.CMD_READ(8'h0B), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .frame_rdy (frame_rdy),
      .bus       (bus),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream sequencer: next byte appears two clocks after each spi_rd.
   always @(posedge clk) begin
      rd_p1 <= bus.spi_rd;
      if (up_reload)  up_cnt <= 8'hFF;
      else if (rd_p1) up_cnt <= up_cnt + 8'd1;
   end
   assign bus.spi_data = up_cnt;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int n_pass, n_total, rd_count, rd_run, half;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit keep);
      logic [7:0] mi;
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.spi_mosi = mo[7-i];
         wait_clk(half);
         bus.spi_sck = 1'b1;
         wait_clk(half);
         mi[7-i] = bus.spi_miso;
         bus.spi_sck = 1'b0;
      end
      if (keep) rx_q.push_back(mi);
   endtask

   task automatic cs_start();
      bus.spi_cs_n = 1'b0;
      wait_clk(4);
   endtask

   task automatic cs_end();
      wait_clk(4);
      bus.spi_cs_n = 1'b1;
      wait_clk(SYNC + 6);
   endtask

   task automatic reload_up();
      up_reload = 1'b1;
      wait_clk(1);
      up_reload = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      logic [7:0] got, e;
      reset_n = 1'b0; frame_rdy = 1'b0; up_reload = 1'b1; half = 6;
      bus.spi_sck = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
      n_pass = 0; n_total = 0; rd_count = 0; rd_run = 0;

      fork
         forever begin
            @(negedge clk);
            while (rx_q.size() > 0) begin
               got = rx_q.pop_front();
               if (exp_q.size() == 0) check(1'b0, "miso_unexpected_byte", got, 0);
               else begin
                  e = exp_q.pop_front();
                  check(got == e, "miso_byte", got, e);
               end
            end
         end
         forever begin
            @(negedge clk);
            if (bus.spi_rd) begin
               rd_run++;
               if (rd_run == 1) rd_count++;
            end else if (rd_run != 0) begin
               check(rd_run == 1, "spi_rd_width", rd_run, 1);
               rd_run = 0;
            end
         end
         begin
            repeat (60000) @(posedge clk);
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
         end
      join_none

      wait_clk(3);
      check(bus.spi_miso == 1'b0,    "reset_miso", bus.spi_miso, 0);
      check(bus.spi_miso_oe == 1'b0, "reset_oe",   bus.spi_miso_oe, 0);
      check(bus.spi_rd == 1'b0,      "reset_rd",   bus.spi_rd, 0);
      check(busy == 1'b0,            "reset_busy", busy, 0);
      reset_n = 1'b1; up_reload = 1'b0;
      wait_clk(8);

      // Status read, frame_rdy = 1 then 0
      frame_rdy = 1'b1; rd_count = 0;
      exp_q.push_back(8'h01);
      cs_start(); spi_bits(8'h00, 8, 1'b1);
      wait_clk(SYNC + 4);
      check(busy == 1'b0,            "status_dummy_busy", busy, 0);
      check(bus.spi_miso_oe == 1'b1, "status_dummy_oe",   bus.spi_miso_oe, 1);
      cs_end();
      check(bus.spi_miso_oe == 1'b0, "status_idle_oe", bus.spi_miso_oe, 0);
      frame_rdy = 1'b0;
      exp_q.push_back(8'h00);
      cs_start(); spi_bits(8'h00, 8, 1'b1); cs_end();
      check(rd_count == 0, "status_rd_count", rd_count, 0);

      // Stream read: command then four bytes
      frame_rdy = 1'b1; reload_up(); rd_count = 0;
      exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      cs_start(); spi_bits(8'h0B, 8, 1'b1);
      for (int i = 0; i < 4; i++) begin
         spi_bits(8'h00, 8, 1'b1);
         check(busy == 1'b1, "stream_busy", busy, 1);
      end
      cs_end();
      check(rd_count == 4, "stream_rd_count", rd_count, 4);
      check(busy == 1'b0,  "stream_end_busy", busy, 0);

      // Wrong command
      reload_up(); rd_count = 0;
      exp_q.push_back(8'h01);
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
      cs_start(); spi_bits(8'h0A, 8, 1'b1);
      for (int i = 0; i < 3; i++) begin
         spi_bits(8'h5A, 8, 1'b1);
         check(busy == 1'b0, "wrongcmd_busy", busy, 0);
      end
      cs_end();
      check(rd_count == 0, "wrongcmd_rd_count", rd_count, 0);

      // Partial byte aborted by CS
      reload_up(); rd_count = 0;
      exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
      cs_start(); spi_bits(8'h0B, 8, 1'b1); spi_bits(8'h00, 8, 1'b1);
      spi_bits(8'h00, 5, 1'b0);
      wait_clk(4);
      bus.spi_cs_n = 1'b1;
      wait_clk(SYNC + 2);
      check(bus.spi_miso_oe == 1'b0, "partial_oe",   bus.spi_miso_oe, 0);
      check(busy == 1'b0,            "partial_busy", busy, 0);
      wait_clk(8);
      check(rd_count == 1, "partial_rd_count", rd_count, 1);

      // Async reset in the middle of the second data byte
      reload_up(); rd_count = 0;
      exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
      cs_start(); spi_bits(8'h0B, 8, 1'b1); spi_bits(8'h00, 8, 1'b1);
      spi_bits(8'h00, 3, 1'b0);
      check(busy == 1'b1, "pre_reset_busy", busy, 1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check(bus.spi_miso == 1'b0,    "areset_miso", bus.spi_miso, 0);
      check(bus.spi_miso_oe == 1'b0, "areset_oe",   bus.spi_miso_oe, 0);
      check(bus.spi_rd == 1'b0,      "areset_rd",   bus.spi_rd, 0);
      check(busy == 1'b0,            "areset_busy", busy, 0);
      wait_clk(2);
      bus.spi_cs_n = 1'b1;
      wait_clk(2);
      reset_n = 1'b1;
      wait_clk(10);
      check(rd_count == 1, "areset_rd_count", rd_count, 1);
      reload_up(); rd_count = 0;
      exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      cs_start(); spi_bits(8'h0B, 8, 1'b1);
      spi_bits(8'h00, 8, 1'b1); spi_bits(8'h00, 8, 1'b1);
      cs_end();
      check(rd_count == 2, "post_reset_rd_count", rd_count, 2);

      // Minimum SCK timing, 16-byte stream
      half = 4; reload_up(); rd_count = 0;
      exp_q.push_back(8'h01);
      for (int i = 0; i < 16; i++) begin
         e = 8'hFF + 8'(i);
         exp_q.push_back(e);
      end
      cs_start(); spi_bits(8'h0B, 8, 1'b1);
      for (int i = 0; i < 16; i++) spi_bits(8'h00, 8, 1'b1);
      cs_end();
      check(rd_count == 16, "mintiming_rd_count", rd_count, 16);

      wait_clk(5);
      check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
